pc_fetch_sequencer: RTL and testbench

- Multi-cycle controller that drives the program counter's load and branch-select inputs.
- Runs the instruction-memory fetch handshake, hands the fetched word to decode, and waits for branch resolution.
- Pulses the PC update exactly once per instruction.
- Sits between the program counter register, instruction memory and the decode/execute stage of the RISC core.

---
 rtl/pc_fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Fetch/issue/resolve controller driving the PC load strobe once per instruction.
// Optional FETCH_PERF_CNT_EN adds retire and stall performance counters.
module pc_fetch_sequencer #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic        br_taken,
    output logic        pc_load,
    output logic        pc_src,
    output logic        busy,
    output logic        fault,
    input  logic        fault_clr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retire_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RESOLVE,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      instr_reg;
    logic             fetch_done;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (fetch_done)
                instr_reg <= imem_rdata;
        end
    end

    // Ack takes priority over the timeout check in the same cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        fetch_done = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    state_next = S_ISSUE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_ISSUE: begin
                if (instr_ready)
                    state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (br_valid)
                    state_next = run ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_reg == S_FETCH);
        instr_valid = (state_reg == S_ISSUE);
        pc_load     = (state_reg == S_RESOLVE) && br_valid;
        pc_src      = pc_load && br_taken;
        busy        = (state_reg != S_IDLE);
        fault       = (state_reg == S_FAULT);
        instr       = instr_reg;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_reg, stall_reg;
    logic        stall_now;

    assign stall_now = ((state_reg == S_FETCH) && !imem_ack) ||
                       ((state_reg == S_ISSUE) && !instr_ready);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            retire_reg <= '0;
            stall_reg  <= '0;
        end else begin
            if (pc_load)
                retire_reg <= retire_reg + 32'd1;
            if (stall_now)
                stall_reg <= stall_reg + 32'd1;
        end
    end

    assign retire_cnt = retire_reg;
    assign stall_cnt  = stall_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized self-checking bench for pc_fetch_sequencer; reacts as imem/decode/execute.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
module tb_pc_fetch_sequencer;

    localparam int TIMEOUT_CYC = 15;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        pc_load;
    logic        pc_src;
    logic        busy;
    logic        fault;
    logic        fault_clr = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;
    int retired_m = 0;
    int stall_m = 0;

    pc_fetch_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
        .clk(clk),
        .areset(areset),
        .run(run),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .br_valid(br_valid),
        .br_taken(br_taken),
        .pc_load(pc_load),
        .pc_src(pc_src),
        .busy(busy),
        .fault(fault),
        .fault_clr(fault_clr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FETCH. Acks after L stall cycles, readies after R,
    // resolves after B. Stray ack/ready/br_valid are injected where they must be ignored.
    task automatic do_instr(input int L, input int R, input int B, input bit tk,
                            input logic [31:0] d, input bit keep_run);
        int loads;
        loads = 0;
        run = 1'b1;
        for (int i = 0; i <= L; i++) begin
            imem_ack    = (i == L);
            imem_rdata  = (i == L) ? d : $urandom;
            instr_ready = 1'(($urandom_range(0, 1)));
            br_valid    = 1'(($urandom_range(0, 1)));
            br_taken    = 1'(($urandom_range(0, 1)));
            #1;
            total++;
            if ({imem_req, instr_valid, pc_load, fault} !== 4'b1000) begin
                bad++;
                $display("FAIL fetch_phase cyc=%0d got req/valid/load/fault=%b want 1000",
                         i, {imem_req, instr_valid, pc_load, fault});
            end
            tick();
        end
        run = keep_run;
        for (int i = 0; i <= R; i++) begin
            imem_ack    = 1'(($urandom_range(0, 1)));
            imem_rdata  = $urandom;
            instr_ready = (i == R);
            br_valid    = 1'(($urandom_range(0, 1)));
            #1;
            total++;
            if ({imem_req, instr_valid, pc_load} !== 3'b010 || instr !== d) begin
                bad++;
                $display("FAIL issue_phase cyc=%0d got req/valid/load=%b instr=%h want 010 instr=%h",
                         i, {imem_req, instr_valid, pc_load}, instr, d);
            end
            tick();
        end
        instr_ready = 1'b0;
        for (int i = 0; i <= B; i++) begin
            imem_ack    = 1'(($urandom_range(0, 1)));
            instr_ready = 1'(($urandom_range(0, 1)));
            br_valid    = (i == B);
            br_taken    = (i == B) ? tk : 1'(($urandom_range(0, 1)));
            #1;
            total++;
            if ({imem_req, instr_valid, busy, pc_load, pc_src} !==
                {3'b001, (i == B), (i == B) && tk}) begin
                bad++;
                $display("FAIL resolve_phase cyc=%0d got req/valid/busy/load/src=%b want %b",
                         i, {imem_req, instr_valid, busy, pc_load, pc_src},
                         {3'b001, (i == B), (i == B) && tk});
            end
            if (pc_load === 1'b1) loads++;
            tick();
        end
        br_valid = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        #1;
        total++;
        if (loads != 1 || imem_req !== keep_run || busy !== keep_run) begin
            bad++;
            $display("FAIL after_resolve loads=%0d req=%b busy=%b want loads=1 req=busy=%b",
                     loads, imem_req, busy, keep_run);
        end
        retired_m++;
        stall_m += L + R;
        $display("instr %h L=%0d R=%0d B=%0d taken=%0d run=%0d retired", d, L, R, B, tk, keep_run);
    endtask

    task automatic test_reset();
        areset = 1'b0; run = 1'b0;
        #3;
        total++;
        if ({imem_req, instr_valid, pc_load, pc_src, busy, fault} !== 6'b0 || instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got flags=%b instr=%h want 0", 
                     {imem_req, instr_valid, pc_load, pc_src, busy, fault}, instr);
        end
        tick();
        areset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            br_valid = 1'(($urandom_range(0, 1)));
            tick();
            total++;
            if ({imem_req, busy, pc_load} !== 3'b000) begin
                bad++;
                $display("FAIL idle_hold got req/busy/load=%b want 000", {imem_req, busy, pc_load});
            end
        end
        br_valid = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_basic();
        run = 1'b1;
        tick();
        do_instr(1, 0, 0, 1'b0, 32'h00500093, 1'b1);
    endtask

    task automatic test_taken();
        do_instr(0, 0, 3, 1'b1, 32'h00a00063, 1'b1);
    endtask

    task automatic test_backpressure();
        do_instr(0, 5, 1, 1'b0, 32'hdeadbeef, 1'b1);
    endtask

    task automatic test_timeout();
        int reqs;
        reqs = 0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            #1;
            if (imem_req === 1'b1) reqs++;
            tick();
        end
        stall_m += TIMEOUT_CYC;
        total++;
        if (reqs != TIMEOUT_CYC || fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout reqs=%0d fault=%b req=%b busy=%b want %0d 1 0 1",
                     reqs, fault, imem_req, busy, TIMEOUT_CYC);
        end
        for (int i = 0; i < 3; i++) begin
            run = 1'(($urandom_range(0, 1)));
            br_valid = 1'(($urandom_range(0, 1)));
            imem_ack = 1'(($urandom_range(0, 1)));
            tick();
            total++;
            if ({fault, imem_req, pc_load} !== 3'b100) begin
                bad++;
                $display("FAIL fault_sticky got fault/req/load=%b want 100", {fault, imem_req, pc_load});
            end
        end
        run = 1'b0; br_valid = 1'b0; imem_ack = 1'b0; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if ({fault, busy} !== 2'b00) begin
            bad++;
            $display("FAIL fault_clr got fault/busy=%b want 00", {fault, busy});
        end
        run = 1'b1;
        tick();
        do_instr(TIMEOUT_CYC - 1, 0, 0, 1'b0, 32'h12345678, 1'b1);
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL ack_on_last got fault=%b want 0", fault);
        end
    endtask

    task automatic test_run_drop();
        do_instr(0, 2, 1, 1'b1, 32'hcafef00d, 1'b0);
        for (int i = 0; i < 2; i++) begin
            br_valid = 1'b1;
            tick();
            total++;
            if ({busy, imem_req, pc_load} !== 3'b000) begin
                bad++;
                $display("FAIL run_drop_idle got busy/req/load=%b want 000", {busy, imem_req, pc_load});
            end
        end
        br_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0badf00d;
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; br_valid = 1'b1;
        #1;
        total++;
        if (pc_load !== 1'b1) begin
            bad++;
            $display("FAIL reach_resolve got pc_load=%b want 1", pc_load);
        end
        #2;
        areset = 1'b0;
        #1;
        total++;
        if ({imem_req, instr_valid, pc_load, pc_src, busy, fault} !== 6'b0 || instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got flags=%b instr=%h want 0",
                     {imem_req, instr_valid, pc_load, pc_src, busy, fault}, instr);
        end
        tick();
        br_valid = 1'b0; run = 1'b0;
        areset = 1'b1;
        tick();
        retired_m = 0;
        stall_m = 0;
        total++;
        if ({busy, pc_load} !== 2'b00) begin
            bad++;
            $display("FAIL after_reset_mid got busy/load=%b want 00", {busy, pc_load});
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (retire_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset got retire=%0d stall=%0d want 0 0", retire_cnt, stall_cnt);
        end
`endif
        $display("reset mid-resolve checked");
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        run = 1'b1;
        tick();
        for (int k = 0; k < 10; k++)
            do_instr(1, 0, $urandom_range(0, 2), 1'(($urandom_range(0, 1))), $urandom, k < 9);
        total++;
        if (retire_cnt !== 32'd10 || stall_cnt !== 32'd10) begin
            bad++;
            $display("FAIL perf_ten got retire=%0d stall=%0d want 10 10", retire_cnt, stall_cnt);
        end
    endtask
`endif

    task automatic test_random();
        run = 1'b1;
        tick();
        for (int k = 0; k < 20; k++)
            do_instr($urandom_range(0, TIMEOUT_CYC - 1), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'(($urandom_range(0, 1))), $urandom, k < 19);
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (retire_cnt !== 32'(retired_m) || stall_cnt !== 32'(stall_m)) begin
            bad++;
            $display("FAIL perf_random got retire=%0d stall=%0d want %0d %0d",
                     retire_cnt, stall_cnt, retired_m, stall_m);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_taken();
        test_backpressure();
        test_timeout();
        test_run_drop();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
